// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/ack data bus, stalls while an access is
// outstanding, and holds the MEM/WB pipeline register with misalignment/timeout codes.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemtoReg,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_RegRtData,
    input  logic [4:0]  MEM_RegWrAddr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] WB_PC,
    output logic        WB_RegWrite,
    output logic [1:0]  WB_MemtoReg,
    output logic [31:0] WB_ALUOut,
    output logic [31:0] WB_MemData,
    output logic [4:0]  WB_RegWrAddr,
    output logic [1:0]  WB_ErrCode
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic       op;
    logic       aligned;
    logic       is_read;
    logic       req;
    logic       done;
    logic [1:0] err;

    assign op      = MEM_MemRead | MEM_MemWrite;
    assign aligned = (MEM_ALUOut[1:0] == 2'b00);
    // Read and write together count as a write.
    assign is_read = MEM_MemRead & ~MEM_MemWrite;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        done    = 1'b0;
        err     = ErrNone;
        unique case (state_q)
            StIdle: begin
                if (op) begin
                    if (!aligned) begin
                        done = 1'b1;
                        err  = ErrMisalign;
                    end else begin
                        req = 1'b1;
                        if (dmem_ack) begin
                            done = 1'b1;
                        end else begin
                            state_d = StWait;
                            cnt_d   = 8'd1;
                        end
                    end
                end
            end
            StWait: begin
                req = 1'b1;
                // Ack takes priority over a coincident timeout.
                if (dmem_ack) begin
                    done    = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CntLast) begin
                    done    = 1'b1;
                    err     = ErrTimeout;
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Gating with reset drops the request immediately on an asynchronous abort.
    assign dmem_req   = reset & req;
    assign mem_stall  = reset & op & ~done;
    assign dmem_we    = MEM_MemWrite;
    assign dmem_addr  = MEM_ALUOut;
    assign dmem_wdata = MEM_RegRtData;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WB_PC        <= 32'd0;
            WB_RegWrite  <= 1'b0;
            WB_MemtoReg  <= 2'd0;
            WB_ALUOut    <= 32'd0;
            WB_MemData   <= 32'd0;
            WB_RegWrAddr <= 5'd0;
            WB_ErrCode   <= 2'd0;
        end else if (mem_stall) begin
            WB_RegWrite <= 1'b0;
            WB_ErrCode  <= ErrNone;
        end else begin
            WB_PC        <= MEM_PC;
            WB_RegWrite  <= MEM_RegWrite & (err == ErrNone);
            WB_MemtoReg  <= MEM_MemtoReg;
            WB_ALUOut    <= MEM_ALUOut;
            WB_MemData   <= (done && is_read && err == ErrNone) ? dmem_rdata : 32'd0;
            WB_RegWrAddr <= MEM_RegWrAddr;
            WB_ErrCode   <= err;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected WB records, a monitor
// pops and compares on every non-stalled edge of an active instruction.
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MEM_PC;
    logic        MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic [1:0]  MEM_MemtoReg;
    logic [31:0] MEM_ALUOut, MEM_RegRtData;
    logic [4:0]  MEM_RegWrAddr;
    logic        dmem_req, dmem_we, dmem_ack, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] WB_PC, WB_ALUOut, WB_MemData;
    logic        WB_RegWrite;
    logic [1:0]  WB_MemtoReg, WB_ErrCode;
    logic [4:0]  WB_RegWrAddr;

    typedef struct packed {
        logic [31:0] pc;
        logic        regwrite;
        logic [1:0]  memtoreg;
        logic [31:0] aluout;
        logic [31:0] memdata;
        logic [4:0]  rdaddr;
        logic [1:0]  err;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    logic tb_active = 1'b0;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .MEM_PC       (MEM_PC),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_MemtoReg (MEM_MemtoReg),
        .MEM_ALUOut   (MEM_ALUOut),
        .MEM_RegRtData(MEM_RegRtData),
        .MEM_RegWrAddr(MEM_RegWrAddr),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .mem_stall    (mem_stall),
        .WB_PC        (WB_PC),
        .WB_RegWrite  (WB_RegWrite),
        .WB_MemtoReg  (WB_MemtoReg),
        .WB_ALUOut    (WB_ALUOut),
        .WB_MemData   (WB_MemData),
        .WB_RegWrAddr (WB_RegWrAddr),
        .WB_ErrCode   (WB_ErrCode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic wb_t wb_now();
        wb_t w;
        w = '{pc: WB_PC, regwrite: WB_RegWrite, memtoreg: WB_MemtoReg, aluout: WB_ALUOut,
              memdata: WB_MemData, rdaddr: WB_RegWrAddr, err: WB_ErrCode};
        return w;
    endfunction

    // Monitor: the MEM/WB register loads a real result on every non-stalled edge.
    always @(posedge clk) begin
        logic st, act, rst;
        wb_t  e;
        st  = mem_stall;
        act = tb_active;
        rst = reset;
        #1;
        if (act && rst && !st) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 128'd1, 128'd0);
            end else begin
                e = sb_q.pop_front();
                check("wb_record", 128'(wb_now()), 128'(e));
            end
        end
    end

    task automatic set_idle();
        MEM_PC = '0; MEM_RegWrite = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
        MEM_MemtoReg = '0; MEM_ALUOut = '0; MEM_RegRtData = '0; MEM_RegWrAddr = '0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_idle();
            tb_active = 1'b0;
        end
    endtask

    // ack_at: cycle index (0 = first request cycle) at which ack is driven; -1 = never.
    task automatic run_op(input string name, input logic [31:0] pc, input logic rw,
                          input logic rd, input logic wr, input logic [1:0] m2r,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rda, input int ack_at, input logic [31:0] rdata,
                          input wb_t exp, input int exp_stalls, input int exp_reqs);
        int  cyc, stalls, reqs;
        logic st;
        @(negedge clk);
        MEM_PC = pc; MEM_RegWrite = rw; MEM_MemRead = rd; MEM_MemWrite = wr;
        MEM_MemtoReg = m2r; MEM_ALUOut = addr; MEM_RegRtData = wdata; MEM_RegWrAddr = rda;
        tb_active = 1'b1;
        sb_q.push_back(exp);
        cyc = 0; stalls = 0; reqs = 0;
        forever begin
            dmem_ack   = (cyc == ack_at);
            dmem_rdata = (cyc == ack_at) ? rdata : 32'h0BAD_0BAD;
            #1;
            if (dmem_req) begin
                reqs++;
                check({name, "_bus"}, 128'({dmem_we, dmem_addr, dmem_wdata}),
                      128'({wr, addr, wdata}));
            end
            st = mem_stall;
            if (st) stalls++;
            @(posedge clk);
            if (!st) break;
            #1;
            check({name, "_bubble"}, 128'({WB_RegWrite, WB_ErrCode}), 128'd0);
            if (cyc >= 50) begin
                check({name, "_cycle_budget"}, 128'd1, 128'd0);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({name, "_stalls"}, 128'(stalls), 128'(exp_stalls));
        check({name, "_reqs"}, 128'(reqs), 128'(exp_reqs));
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        #3;
        check("reset_wb", 128'(wb_now()), 128'd0);
        check("reset_req_stall", 128'({dmem_req, mem_stall}), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        run_op("zero_wait_load", 32'h100, 1, 1, 0, 2'b01, 32'h10, 32'h0, 5'd8, 0, 32'hDEADBEEF,
               '{32'h100, 1'b1, 2'b01, 32'h10, 32'hDEADBEEF, 5'd8, 2'b00}, 0, 1);
        idle(1);
        run_op("store_3wait", 32'h104, 0, 0, 1, 2'b00, 32'h20, 32'h12345678, 5'd0, 3, 32'h0,
               '{32'h104, 1'b0, 2'b00, 32'h20, 32'h0, 5'd0, 2'b00}, 3, 4);
        idle(1);
        run_op("misaligned_load", 32'h108, 1, 1, 0, 2'b01, 32'h13, 32'h0, 5'd9, 0, 32'h11111111,
               '{32'h108, 1'b0, 2'b01, 32'h13, 32'h0, 5'd9, 2'b01}, 0, 0);
        idle(1);
        run_op("timeout_load", 32'h10C, 1, 1, 0, 2'b01, 32'h30, 32'h0, 5'd10, -1, 32'h0,
               '{32'h10C, 1'b0, 2'b01, 32'h30, 32'h0, 5'd10, 2'b10}, 3, 4);
        run_op("ack_at_limit", 32'h110, 1, 1, 0, 2'b01, 32'h34, 32'h0, 5'd11, 3, 32'hA5A5_5A5A,
               '{32'h110, 1'b1, 2'b01, 32'h34, 32'hA5A5_5A5A, 5'd11, 2'b00}, 3, 4);
        idle(1);

        // Abort a load two cycles into its wait with an asynchronous reset.
        @(negedge clk);
        MEM_PC = 32'h114; MEM_RegWrite = 1; MEM_MemRead = 1; MEM_ALUOut = 32'h40;
        MEM_RegWrAddr = 5'd12; dmem_ack = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_reset_req", 128'({dmem_req, mem_stall}), 128'({1'b1, 1'b1}));
        reset = 1'b0;
        #1;
        check("midreset_req_stall", 128'({dmem_req, mem_stall}), 128'd0);
        check("midreset_wb", 128'(wb_now()), 128'd0);
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        run_op("post_reset_misaligned", 32'h118, 1, 1, 0, 2'b01, 32'h42, 32'h0, 5'd13, -1, 32'h0,
               '{32'h118, 1'b0, 2'b01, 32'h42, 32'h0, 5'd13, 2'b01}, 0, 0);
        run_op("post_reset_load", 32'h11C, 1, 1, 0, 2'b01, 32'h44, 32'h0, 5'd14, 1, 32'h0BEE_F00D,
               '{32'h11C, 1'b1, 2'b01, 32'h44, 32'h0BEE_F00D, 5'd14, 2'b00}, 1, 2);
        idle(1);

        run_op("b2b_load_a", 32'h200, 1, 1, 0, 2'b01, 32'h50, 32'h0, 5'd1, 0, 32'h1111_2222,
               '{32'h200, 1'b1, 2'b01, 32'h50, 32'h1111_2222, 5'd1, 2'b00}, 0, 1);
        run_op("b2b_load_b", 32'h204, 1, 1, 0, 2'b01, 32'h54, 32'h0, 5'd2, 0, 32'h3333_4444,
               '{32'h204, 1'b1, 2'b01, 32'h54, 32'h3333_4444, 5'd2, 2'b00}, 0, 1);
        // Ack with no request must be ignored.
        run_op("b2b_alu", 32'h208, 1, 0, 0, 2'b00, 32'hCAFE0000, 32'h0, 5'd3, 0, 32'h5555_6666,
               '{32'h208, 1'b1, 2'b00, 32'hCAFE0000, 32'h0, 5'd3, 2'b00}, 0, 0);
        idle(3);

        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
